branch_resolve_stage: RTL and testbench

//  EX-stage branch/jump resolution, directly downstream of the operand comparator.

---
 rtl/branch_pkg.sv | 23 ++
 rtl/branch_resolve_stage_cmp.sv | 14 +
 rtl/branch_resolve_stage.sv | 190 +++++++++++++++++++
 tb/tb_branch_resolve_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for EX-stage branch resolution.
package branch_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_BR   = 2'b01,
        KIND_JAL  = 2'b10,
        KIND_JALR = 2'b11
    } kind_e;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_REDIR = 1'b1
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_resolve_stage_cmp.sv
// Operand comparator: unsigned less-than and equality flags, purely combinational.
module branch_resolve_stage_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            less_o,
    output logic            equal_o
);

    assign less_o  = (rs1_i < rs2_i);
    assign equal_o = (rs1_i == rs2_i);

endmodule

// File: rtl/branch_resolve_stage.sv
// EX-stage branch/jump resolution with one-cycle result register and redirect handshake to fetch.
// Optional saturating statistics counters when BRANCH_STATS_EN is defined.
module branch_resolve_stage
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic [XLEN-1:0]   out_link,
    output logic              out_illegal,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [XLEN-1:0]   redir_pc,
`ifdef BRANCH_STATS_EN
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_taken,
`endif
    output logic              squash
);

    kind_e           kind;
    logic            lt;
    logic            eq;
    logic            slt;
    logic            br_cond;
    logic            br_illegal;
    logic            taken;
    logic            illegal;
    logic            accept;
    logic [XLEN-1:0] tgt_pc_rel;
    logic [XLEN-1:0] tgt_jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    state_e          state_q, state_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            out_taken_q, out_taken_d;
    logic            out_illegal_q, out_illegal_d;
    logic [XLEN-1:0] out_link_q, out_link_d;

    assign kind = kind_e'(in_kind);

    branch_resolve_stage_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1_i   (in_rs1),
        .rs2_i   (in_rs2),
        .less_o  (lt),
        .equal_o (eq)
    );

    // Signed less-than derived from the unsigned flag: differing signs decide directly.
    assign slt = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) ? in_rs1[XLEN-1] : lt;

    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        case (in_funct3)
            F3_BEQ:  br_cond = eq;
            F3_BNE:  br_cond = !eq;
            F3_BLT:  br_cond = slt;
            F3_BGE:  br_cond = !slt;
            F3_BLTU: br_cond = lt;
            F3_BGEU: br_cond = !lt;
            default: br_illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (kind)
            KIND_BR: begin
                taken   = br_cond;
                illegal = br_illegal;
            end
            KIND_JAL:  taken = 1'b1;
            KIND_JALR: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    assign tgt_pc_rel   = in_pc + in_imm;
    assign tgt_jalr_sum = in_rs1 + in_imm;
    assign target       = (kind == KIND_JALR) ? {tgt_jalr_sum[XLEN-1:1], 1'b0} : tgt_pc_rel;
    assign link         = in_pc + XLEN'(4);

    assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        squash        = 1'b0;
        case (state_q)
            S_RUN: begin
                if (accept && taken) begin
                    state_d       = S_REDIR;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = target;
                end
            end
            S_REDIR: begin
                if (redir_ready) begin
                    squash        = 1'b1;
                    state_d       = S_RUN;
                    redir_valid_d = 1'b0;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        out_valid_d   = out_valid_q && !out_ready;
        out_taken_d   = out_taken_q;
        out_illegal_d = out_illegal_q;
        out_link_d    = out_link_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_taken_d   = taken;
            out_illegal_d = illegal;
            out_link_d    = link;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_link_q    <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            out_valid_q   <= out_valid_d;
            out_taken_q   <= out_taken_d;
            out_illegal_q <= out_illegal_d;
            out_link_q    <= out_link_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_taken   = out_taken_q;
    assign out_illegal = out_illegal_q;
    assign out_link    = out_link_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_tk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_tk_q <= '0;
        end else if (accept) begin
            if (kind == KIND_BR && stat_br_q != '1) begin
                stat_br_q <= stat_br_q + STAT_W'(1);
            end
            if (taken && stat_tk_q != '1) begin
                stat_tk_q <= stat_tk_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_taken    = stat_tk_q;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed and randomized bench for branch_resolve_stage against a behavioural reference model.
module tb_branch_resolve_stage;

    localparam int XLEN   = 32;
    localparam int STAT_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [2:0]        in_funct3;
    logic [XLEN-1:0]   in_pc, in_imm, in_rs1, in_rs2;
    logic              out_valid, out_ready, out_taken, out_illegal;
    logic [XLEN-1:0]   out_link;
    logic              redir_valid, redir_ready;
    logic [XLEN-1:0]   redir_pc;
    logic              squash;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] stat_branches, stat_taken;
`endif

    branch_resolve_stage #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_funct3     (in_funct3),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_link      (out_link),
        .out_illegal   (out_illegal),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
`ifdef BRANCH_STATS_EN
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
`endif
        .squash        (squash)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: one-deep result slot plus pending redirect.
    bit              m_res_full;
    bit              m_res_taken;
    bit              m_res_ill;
    bit [XLEN-1:0]   m_res_link;
    bit              m_redir;
    bit [XLEN-1:0]   m_redir_pc;
    bit [STAT_W-1:0] m_st_br;
    bit [STAT_W-1:0] m_st_tk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_eval(input logic [1:0] kind, input logic [2:0] f3,
                            input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                            input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                            output bit taken, output bit ill,
                            output bit [XLEN-1:0] tgt, output bit [XLEN-1:0] lnk);
        taken = 1'b0;
        ill   = 1'b0;
        lnk   = pc + 32'd4;
        tgt   = pc + imm;
        if (kind == 2'b01) begin
            case (f3)
                3'd0: taken = (rs1 == rs2);
                3'd1: taken = (rs1 != rs2);
                3'd4: taken = ($signed(rs1) <  $signed(rs2));
                3'd5: taken = ($signed(rs1) >= $signed(rs2));
                3'd6: taken = (rs1 <  rs2);
                3'd7: taken = (rs1 >= rs2);
                default: ill = 1'b1;
            endcase
        end else if (kind == 2'b10) begin
            taken = 1'b1;
        end else if (kind == 2'b11) begin
            taken = 1'b1;
            tgt   = (rs1 + imm) & ~32'd1;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(m_res_full));
        if (m_res_full) begin
            check("out_taken", 64'(out_taken), 64'(m_res_taken));
            check("out_illegal", 64'(out_illegal), 64'(m_res_ill));
            check("out_link", 64'(out_link), 64'(m_res_link));
        end
        check("redir_valid", 64'(redir_valid), 64'(m_redir));
        if (m_redir) check("redir_pc", 64'(redir_pc), 64'(m_redir_pc));
`ifdef BRANCH_STATS_EN
        check("stat_branches", 64'(stat_branches), 64'(m_st_br));
        check("stat_taken", 64'(stat_taken), 64'(m_st_tk));
`endif
    endtask

    // One clock: check handshake-side outputs, advance the model, check registered outputs.
    task automatic tick();
        bit exp_rdy, hs, tk, il;
        bit [XLEN-1:0] tg, lk;
        #1;
        exp_rdy = !m_redir && (!m_res_full || out_ready);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("squash", 64'(squash), 64'(m_redir && redir_ready));
        hs = in_valid && exp_rdy;
        ref_eval(in_kind, in_funct3, in_pc, in_imm, in_rs1, in_rs2, tk, il, tg, lk);
        @(posedge clk);
        if (m_res_full && out_ready) m_res_full = 1'b0;
        if (m_redir && redir_ready) m_redir = 1'b0;
        if (hs) begin
            m_res_full  = 1'b1;
            m_res_taken = tk;
            m_res_ill   = il;
            m_res_link  = lk;
            if (tk) begin
                m_redir    = 1'b1;
                m_redir_pc = tg;
            end
            if (in_kind == 2'b01 && m_st_br != '1) m_st_br++;
            if (tk && m_st_tk != '1) m_st_tk++;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_res_full = 1'b0;
        m_redir    = 1'b0;
        m_st_br    = '0;
        m_st_tk    = '0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_taken", 64'(out_taken), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_out_link", 64'(out_link), 64'd0);
        check("rst_redir_valid", 64'(redir_valid), 64'd0);
        check("rst_redir_pc", 64'(redir_pc), 64'd0);
        check("rst_squash", 64'(squash), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'(out_ready));
`ifdef BRANCH_STATS_EN
        check("rst_stat_branches", 64'(stat_branches), 64'd0);
        check("rst_stat_taken", 64'(stat_taken), 64'd0);
`endif
    endtask

    task automatic set_in(input logic v, input logic [1:0] k, input logic [2:0] f3,
                          input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                          input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
        in_valid  = v;
        in_kind   = k;
        in_funct3 = f3;
        in_pc     = pc;
        in_imm    = imm;
        in_rs1    = rs1;
        in_rs2    = rs2;
    endtask

    initial begin
        logic [XLEN-1:0] r1;
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        out_ready   = 1'b1;
        redir_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // beq taken, redirect held for 5 cycles, then squash and re-accept
        set_in(1'b1, 2'b01, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5);
        tick();
        check("beq_taken", 64'(out_taken), 64'd1);
        check("beq_redir_pc", 64'(redir_pc), 64'h120);
        set_in(1'b1, 2'b00, 3'd0, 32'h104, 32'h0, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check("hold_redir_pc", 64'(redir_pc), 64'h120);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        tick();
        check("accept_after_squash", 64'(out_valid), 64'd1);

        // blt signed taken; bltu same operands not taken
        set_in(1'b1, 2'b01, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("blt_taken", 64'(out_taken), 64'd1);
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        set_in(1'b1, 2'b01, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("bltu_not_taken", 64'(out_taken), 64'd0);
        check("bltu_no_redir", 64'(redir_valid), 64'd0);

        // jalr clears bit 0; jal target wraps
        set_in(1'b1, 2'b11, 3'd0, 32'h300, 32'h0, 32'h1003, 32'd0);
        tick();
        check("jalr_pc", 64'(redir_pc), 64'h1002);
        check("jalr_link", 64'(out_link), 64'h304);
        redir_ready = 1'b1;
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        tick();
        redir_ready = 1'b0;
        set_in(1'b1, 2'b10, 3'd0, 32'hFFFF_FFFC, 32'd8, 32'd0, 32'd0);
        tick();
        check("jal_wrap_pc", 64'(redir_pc), 64'h4);
        check("jal_wrap_link", 64'(out_link), 64'h0);
        redir_ready = 1'b1;
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        tick();
        redir_ready = 1'b0;

        // MEM backpressure with back-to-back not-taken beats; second is illegal funct3
        out_ready = 1'b0;
        set_in(1'b1, 2'b01, 3'd1, 32'h400, 32'h8, 32'd7, 32'd7);
        tick();
        set_in(1'b1, 2'b01, 3'd2, 32'h500, 32'h8, 32'd1, 32'd2);
        tick();
        tick();
        check("stall_keeps_first", 64'(out_link), 64'h404);
        out_ready = 1'b1;
        tick();
        check("second_beat_illegal", 64'(out_illegal), 64'd1);
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        tick();

        // reset during a pending redirect
        set_in(1'b1, 2'b10, 3'd0, 32'h600, 32'h10, 32'd0, 32'd0);
        tick();
        set_in(1'b0, 2'b00, 3'd0, '0, '0, '0, '0);
        do_reset();
        tick();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            r1 = $urandom;
            set_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), $urandom, $urandom, r1,
                   ($urandom_range(0, 3) == 0) ? r1 : $urandom);
            out_ready   = 1'($urandom_range(0, 3) != 0);
            redir_ready = 1'($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
